ghr_index_gen: RTL and testbench
================================

GHR_INDEX_GEN -- requirements
Module: ghr_index_gen

Interface
REQ-001 SHALL provide parameter PC_W, default 8, width of the branch PC.
REQ-002 SHALL provide parameter CKPT_DEPTH, default 4, number of in-flight prediction checkpoints (power of two, 2..8).
REQ-003 SHALL have ports as follows; reset reset, asynchronous, active-high; clock clk.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 req_valid  in  1  fetch stage requests a prediction.
REQ-007 req_pc  in  PC_W  branch PC for the request.
REQ-008 req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-009 bht_prediction  in  1  prediction bit returned combinationally by the 16-entry BHT for bht_index.
REQ-010 resolve_valid  in  1  oldest in-flight branch resolves this cycle.
REQ-011 resolve_taken  in  1  actual outcome of the resolving branch.
REQ-012 bht_index  out  4  BHT index, lookup or update.
REQ-013 bht_update_en  out  1  BHT counter update strobe (drives BHT predict_enable).
REQ-014 bht_outcome  out  1  outcome for BHT update.
REQ-015 pred_valid  out  1  prediction issued this cycle; pred_taken  out  1  predicted direction.
REQ-016 mispredict  out  1  registered one-cycle pulse after a mispredicted resolve.
REQ-017 ghr  out  4  current speculative global history; inflight  out  $clog2(CKPT_DEPTH)+1  occupied checkpoints.
REQ-018 resolve_err  out  1  sticky flag, resolve seen with no in-flight checkpoint.

Function
REQ-019 Lookup index SHALL be req_pc[5:2] XOR ghr.
REQ-020 req_ready SHALL equal (inflight != CKPT_DEPTH) AND NOT resolve_valid; resolve has port priority.
REQ-021 On accept: pred_valid=1, pred_taken=bht_prediction same cycle (zero latency); checkpoint {index, ghr, bht_prediction} pushed at tail; ghr <= {ghr[2:0], bht_prediction} next edge.
REQ-022 bht_index SHALL be head-checkpoint index when resolve_valid and inflight>0, else lookup index.
REQ-023 bht_update_en SHALL equal resolve_valid AND inflight>0; bht_outcome = resolve_taken.
REQ-024 Resolve with inflight>0 SHALL pop the head; if resolve_taken == head prediction, ghr unchanged.
REQ-025 Mispredict (resolve_taken != head prediction): ghr <= {head_ghr[2:0], resolve_taken}; all checkpoints flushed (inflight <= 0); mispredict=1 next cycle only.
REQ-026 Resolve with inflight==0: no update strobe, no pop, resolve_err <= 1 (held until reset).
REQ-027 Checkpoint pointers SHALL wrap modulo CKPT_DEPTH; full blocks requests, never overwrites.
REQ-028 Back-to-back accepts SHALL each see the ghr updated by the previous accept.

Reset
REQ-029 Reset SHALL set ghr=0, inflight=0, pointers=0, mispredict=0, resolve_err=0, stats counters=0.
REQ-030 Reset mid-operation SHALL discard all checkpoints; first post-reset request indexes req_pc[5:2].

Configuration
REQ-031 Macro GHR_INDEX_STATS_EN, when defined, SHALL add outputs stat_preds[15:0] (accepted requests) and stat_mispreds[15:0] (mispredicts), each saturating at 16'hFFFF.
REQ-032 Without GHR_INDEX_STATS_EN the ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-033 Shared package bp_pkg SHALL hold GHR_W=4, BHT_IDX_W=4 and the checkpoint struct typedef {idx, ghr, pred}.
REQ-034 Sub-module ckpt_fifo (push, pop, flush, head, count) SHALL hold the checkpoints; index/GHR logic stays in ghr_index_gen.

Verification
REQ-035 After reset, req_pc=8'h34, bht_prediction=1 -> bht_index=4'hD, pred_taken=1, next ghr=4'b0001, inflight=1.
REQ-036 Four accepts with bht_prediction=1 from ghr=0 -> ghr=4'hF, inflight=4, req_ready=0 on fifth request.
REQ-037 Resolve head (pred 1) with resolve_taken=0 -> bht_update_en=1, bht_index=head idx, ghr={head_ghr[2:0],0}, inflight=0, mispredict high exactly one cycle.
REQ-038 resolve_valid and req_valid same cycle -> req_ready=0, bht_index=head index, request accepted next cycle.
REQ-039 resolve_valid with inflight=0 -> bht_update_en=0, resolve_err=1 until reset; async reset mid-stream -> all outputs at reset values without clock.
REQ-040 With GHR_INDEX_STATS_EN, 65540 accepts -> stat_preds=16'hFFFF.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: history/index widths and the in-flight checkpoint record.
package bp_pkg;

    localparam int unsigned GHR_W     = 4;
    localparam int unsigned BHT_IDX_W = 4;

    // Everything needed to update the BHT and repair history when the branch resolves.
    typedef struct packed {
        logic [BHT_IDX_W-1:0] idx;
        logic [GHR_W-1:0]     ghr;
        logic                 pred;
    } ckpt_t;

endpackage

// File: rtl/ckpt_fifo.sv
// In-order checkpoint queue for predicted branches; pointers wrap modulo DEPTH (power of two).
module ckpt_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  ckpt_t            push_data,
    input  logic             pop,
    input  logic             flush,
    output ckpt_t            head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    ckpt_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Payload needs no reset: only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ghr_index_gen.sv
// Gshare index generation with speculative GHR and checkpoint-based repair on mispredict.
// Optional GHR_INDEX_STATS_EN adds saturating prediction / mispredict counters.
module ghr_index_gen
    import bp_pkg::*;
#(
    parameter int unsigned PC_W       = 8,
    parameter int unsigned CKPT_DEPTH = 4,
    localparam int unsigned CNT_W     = $clog2(CKPT_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [PC_W-1:0]      req_pc,
    output logic                 req_ready,
    input  logic                 bht_prediction,
    input  logic                 resolve_valid,
    input  logic                 resolve_taken,
    output logic [BHT_IDX_W-1:0] bht_index,
    output logic                 bht_update_en,
    output logic                 bht_outcome,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic                 mispredict,
    output logic [GHR_W-1:0]     ghr,
    output logic [CNT_W-1:0]     inflight,
    output logic                 resolve_err
`ifdef GHR_INDEX_STATS_EN
    ,
    output logic [15:0]          stat_preds,
    output logic [15:0]          stat_mispreds
`endif
);

    logic [GHR_W-1:0]     ghr_q, ghr_d;
    logic                 mispredict_q;
    logic                 resolve_err_q;
    logic [BHT_IDX_W-1:0] lookup_idx;
    logic                 accept, do_update, mispredict_now;
    logic                 fifo_full, fifo_empty;
    ckpt_t                head, push_data;

    logic unused_pc;
    assign unused_pc = ^{req_pc[PC_W-1:6], req_pc[1:0]};

    assign lookup_idx = req_pc[5:2] ^ ghr_q;

    // Resolve owns the shared BHT index port, so requests stall while it is active.
    assign req_ready      = !fifo_full && !resolve_valid;
    assign accept         = req_valid && req_ready;
    assign do_update      = resolve_valid && !fifo_empty;
    assign mispredict_now = do_update && (resolve_taken != head.pred);

    assign bht_index     = do_update ? head.idx : lookup_idx;
    assign bht_update_en = do_update;
    assign bht_outcome   = resolve_taken;
    assign pred_valid    = accept;
    assign pred_taken    = accept && bht_prediction;

    assign push_data = '{idx: lookup_idx, ghr: ghr_q, pred: bht_prediction};

    ckpt_fifo #(
        .DEPTH (CKPT_DEPTH)
    ) u_ckpt_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (push_data),
        .pop       (do_update),
        .flush     (mispredict_now),
        .head      (head),
        .count     (inflight),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Repair rebuilds history as it stood before the bad branch, plus its real outcome.
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict_now) begin
            ghr_d = {head.ghr[GHR_W-2:0], resolve_taken};
        end else if (accept) begin
            ghr_d = {ghr_q[GHR_W-2:0], bht_prediction};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_q         <= '0;
            mispredict_q  <= 1'b0;
            resolve_err_q <= 1'b0;
        end else begin
            ghr_q         <= ghr_d;
            mispredict_q  <= mispredict_now;
            resolve_err_q <= resolve_err_q || (resolve_valid && fifo_empty);
        end
    end

    assign ghr         = ghr_q;
    assign mispredict  = mispredict_q;
    assign resolve_err = resolve_err_q;

`ifdef GHR_INDEX_STATS_EN
    logic [15:0] stat_preds_q, stat_mispreds_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_preds_q    <= '0;
            stat_mispreds_q <= '0;
        end else begin
            if (accept && stat_preds_q != 16'hFFFF) begin
                stat_preds_q <= stat_preds_q + 16'd1;
            end
            if (mispredict_now && stat_mispreds_q != 16'hFFFF) begin
                stat_mispreds_q <= stat_mispreds_q + 16'd1;
            end
        end
    end

    assign stat_preds    = stat_preds_q;
    assign stat_mispreds = stat_mispreds_q;
`endif

endmodule

// File: tb/tb_ghr_index_gen.sv
// Directed scoreboard bench for ghr_index_gen; monitor checks predictions and BHT updates.
module tb_ghr_index_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [7:0] req_pc;
    logic       req_ready;
    logic       bht_prediction;
    logic       resolve_valid;
    logic       resolve_taken;
    logic [3:0] bht_index;
    logic       bht_update_en;
    logic       bht_outcome;
    logic       pred_valid;
    logic       pred_taken;
    logic       mispredict;
    logic [3:0] ghr;
    logic [2:0] inflight;
    logic       resolve_err;
`ifdef GHR_INDEX_STATS_EN
    logic [15:0] stat_preds;
    logic [15:0] stat_mispreds;
`endif

    typedef struct packed {
        logic [3:0] idx;
        logic       bitv;
    } exp_t;

    exp_t pred_q[$];
    exp_t upd_q[$];
    int   total = 0;
    int   bad   = 0;
    logic sb_en = 1'b1;

    always #5 clk = ~clk;

    ghr_index_gen #(
        .PC_W       (8),
        .CKPT_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_pc         (req_pc),
        .req_ready      (req_ready),
        .bht_prediction (bht_prediction),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .bht_index      (bht_index),
        .bht_update_en  (bht_update_en),
        .bht_outcome    (bht_outcome),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .mispredict     (mispredict),
        .ghr            (ghr),
        .inflight       (inflight),
        .resolve_err    (resolve_err)
`ifdef GHR_INDEX_STATS_EN
        ,
        .stat_preds     (stat_preds),
        .stat_mispreds  (stat_mispreds)
`endif
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented prediction/update must match the oldest expectation.
    always @(negedge clk) begin
        if (sb_en && !reset) begin
            if (pred_valid) begin
                total++;
                if (pred_q.size() == 0) begin
                    bad++;
                    $display("FAIL pred_unexpected: got idx=%h taken=%b expected none",
                             bht_index, pred_taken);
                end else begin
                    exp_t e;
                    e = pred_q.pop_front();
                    if ({bht_index, pred_taken} !== {e.idx, e.bitv}) begin
                        bad++;
                        $display("FAIL pred: got idx=%h taken=%b expected idx=%h taken=%b",
                                 bht_index, pred_taken, e.idx, e.bitv);
                    end
                end
            end
            if (bht_update_en) begin
                total++;
                if (upd_q.size() == 0) begin
                    bad++;
                    $display("FAIL update_unexpected: got idx=%h outcome=%b expected none",
                             bht_index, bht_outcome);
                end else begin
                    exp_t e;
                    e = upd_q.pop_front();
                    if ({bht_index, bht_outcome} !== {e.idx, e.bitv}) begin
                        bad++;
                        $display("FAIL update: got idx=%h outcome=%b expected idx=%h outcome=%b",
                                 bht_index, bht_outcome, e.idx, e.bitv);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid     = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
    endtask

    // One accepted request; expected prediction is queued for the monitor.
    task automatic request(input logic [7:0] pc, input logic pred, input logic [3:0] exp_idx);
        req_valid      = 1'b1;
        req_pc         = pc;
        bht_prediction = pred;
        pred_q.push_back('{idx: exp_idx, bitv: pred});
        next_cycle();
        idle();
    endtask

    initial begin
        reset          = 1'b1;
        req_pc         = 8'h00;
        bht_prediction = 1'b0;
        idle();
        #12;
        check("reset_ghr", 16'(ghr), 16'h0);
        check("reset_inflight", 16'(inflight), 16'h0);
        check("reset_mispredict", 16'(mispredict), 16'h0);
        check("reset_err", 16'(resolve_err), 16'h0);
        check("reset_ready", 16'(req_ready), 16'h1);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // First lookup from empty history: 0x34[5:2] = D.
        request(8'h34, 1'b1, 4'hD);
        check("first_ghr", 16'(ghr), 16'h1);
        check("first_inflight", 16'(inflight), 16'h1);

        // Each accept sees the history shifted by the previous one.
        request(8'h34, 1'b1, 4'hC);
        request(8'h00, 1'b1, 4'h3);
        request(8'h3C, 1'b1, 4'h8);
        check("fill_ghr", 16'(ghr), 16'hF);
        check("fill_inflight", 16'(inflight), 16'h4);

        // Full: fifth request must be refused.
        req_valid = 1'b1;
        req_pc    = 8'h20;
        #2;
        check("full_ready", 16'(req_ready), 16'h0);
        next_cycle();
        idle();
        check("full_inflight", 16'(inflight), 16'h4);

        // Correct resolve of head {D,0,1}.
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        upd_q.push_back('{idx: 4'hD, bitv: 1'b1});
        next_cycle();
        idle();
        check("hit_ghr", 16'(ghr), 16'hF);
        check("hit_inflight", 16'(inflight), 16'h3);
        check("hit_mispredict", 16'(mispredict), 16'h0);

        // Resolve and request together: resolve wins, request goes next cycle.
        resolve_valid  = 1'b1;
        resolve_taken  = 1'b1;
        req_valid      = 1'b1;
        req_pc         = 8'h10;
        bht_prediction = 1'b0;
        upd_q.push_back('{idx: 4'hC, bitv: 1'b1});
        #2;
        check("collide_ready", 16'(req_ready), 16'h0);
        check("collide_index", 16'(bht_index), 16'hC);
        next_cycle();
        resolve_valid = 1'b0;
        pred_q.push_back('{idx: 4'hB, bitv: 1'b0});
        next_cycle();
        idle();
        check("collide_ghr", 16'(ghr), 16'hE);
        check("collide_inflight", 16'(inflight), 16'h3);

        // Mispredict on head {3,3,1}: history repaired to {011,0}, all flushed.
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        upd_q.push_back('{idx: 4'h3, bitv: 1'b0});
        next_cycle();
        idle();
        check("mp_pulse", 16'(mispredict), 16'h1);
        check("mp_ghr", 16'(ghr), 16'h6);
        check("mp_inflight", 16'(inflight), 16'h0);
        next_cycle();
        check("mp_pulse_end", 16'(mispredict), 16'h0);

        // Resolve with nothing in flight: no strobe, sticky error.
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        #2;
        check("empty_update_en", 16'(bht_update_en), 16'h0);
        next_cycle();
        idle();
        check("err_set", 16'(resolve_err), 16'h1);
        next_cycle();
        check("err_held", 16'(resolve_err), 16'h1);

        // Repaired history feeds the next lookup: D ^ 6 = B.
        request(8'h34, 1'b1, 4'hB);
        check("post_mp_ghr", 16'(ghr), 16'hD);
        check("post_mp_inflight", 16'(inflight), 16'h1);

        // Asynchronous reset between edges.
        #2;
        reset = 1'b1;
        #1;
        check("areset_ghr", 16'(ghr), 16'h0);
        check("areset_inflight", 16'(inflight), 16'h0);
        check("areset_err", 16'(resolve_err), 16'h0);
        check("areset_mispredict", 16'(mispredict), 16'h0);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        request(8'h34, 1'b0, 4'hD);
        check("post_reset_ghr", 16'(ghr), 16'h0);
        check("post_reset_inflight", 16'(inflight), 16'h1);

`ifdef GHR_INDEX_STATS_EN
        sb_en = 1'b0;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            req_valid      = 1'b1;
            bht_prediction = 1'b1;
            next_cycle();
            req_valid     = 1'b0;
            resolve_valid = 1'b1;
            resolve_taken = 1'b1;
            next_cycle();
            resolve_valid = 1'b0;
        end
        check("stat_preds_sat", stat_preds, 16'hFFFF);
        check("stat_mispreds", stat_mispreds, 16'h0000);
        sb_en = 1'b1;
`endif

        next_cycle();
        check("pred_q_drained", 16'(pred_q.size()), 16'h0);
        check("upd_q_drained", 16'(upd_q.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
